alu_control_md: RTL and testbench

Second-generation ALU control for the single-cycle RV32 core. It decodes aluOp/funct3/funct7 into the single-cycle ALU control code, covering the full RV32I ALU op set. It also adds an iterative multi-cycle multiply/divide engine for RV32M, which stalls the core until its result is ready. It sits between the main decoder and the ALU, and its result is muxed into the writeback path when aluCtl = MD.

---
 rtl/alu_control_md_if.sv | 27 ++
 rtl/alu_control_md.sv | 183 ++++++++++++++++++
 tb/tb_alu_control_md.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_md_if.sv
// Decode-side bus between the core's main decoder and alu_control_md.
// The master drives the instruction fields and operands; the slave returns control and results.
interface alu_control_md_if #(
   parameter int unsigned XLEN = 32
);
   logic            valid;
   logic [1:0]      aluOp;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] opA;
   logic [XLEN-1:0] opB;
   logic [3:0]      aluCtl;
   logic            stall;
   logic            mdBusy;
   logic            mdDone;
   logic [XLEN-1:0] mdResult;

   modport master (
      output valid, aluOp, funct3, funct7, opA, opB,
      input  aluCtl, stall, mdBusy, mdDone, mdResult
   );

   modport slave (
      input  valid, aluOp, funct3, funct7, opA, opB,
      output aluCtl, stall, mdBusy, mdDone, mdResult
   );
endinterface

// File: rtl/alu_control_md.sv
// ALU control decode plus an iterative RV32M multiply/divide engine.
// The engine uses one shift-add or restoring-divide step per cycle and stalls the core.
module alu_control_md #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = $clog2(XLEN)
) (
   input logic             clk,
   input logic             rst,
   alu_control_md_if.slave bus_io
);
   localparam logic [3:0] CtlAnd  = 4'b0000;
   localparam logic [3:0] CtlOr   = 4'b0001;
   localparam logic [3:0] CtlAdd  = 4'b0010;
   localparam logic [3:0] CtlXor  = 4'b0011;
   localparam logic [3:0] CtlSll  = 4'b0100;
   localparam logic [3:0] CtlSrl  = 4'b0101;
   localparam logic [3:0] CtlSub  = 4'b0110;
   localparam logic [3:0] CtlSra  = 4'b0111;
   localparam logic [3:0] CtlSlt  = 4'b1000;
   localparam logic [3:0] CtlSltu = 4'b1001;
   localparam logic [3:0] CtlMd   = 4'b1111;
   localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d, result_q, result_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;

   logic              is_md, launch, fast, div_zero, div_ovf;
   logic              signed_a, signed_b, a_neg, b_neg;
   logic [2:0]        f3;
   logic [XLEN-1:0]   abs_a, abs_b, fast_res;
   logic [3:0]        alu_ctl;
   logic              stall, md_busy, md_done;

   assign f3     = bus_io.funct3;
   assign is_md  = (bus_io.aluOp == 2'b10) && (bus_io.funct7 == 7'b0000001);
   assign launch = (state_q == StIdle) && bus_io.valid && is_md;

   always_comb begin
      alu_ctl = CtlAdd;
      if (bus_io.aluOp == 2'b01) begin
         alu_ctl = CtlSub;
      end else if (bus_io.aluOp[1]) begin
         if (is_md) begin
            alu_ctl = CtlMd;
         end else begin
            unique case (f3)
               3'b000: alu_ctl = (!bus_io.aluOp[0] && bus_io.funct7[5]) ? CtlSub : CtlAdd;
               3'b001: alu_ctl = CtlSll;
               3'b010: alu_ctl = CtlSlt;
               3'b011: alu_ctl = CtlSltu;
               3'b100: alu_ctl = CtlXor;
               3'b101: alu_ctl = bus_io.funct7[5] ? CtlSra : CtlSrl;
               3'b110: alu_ctl = CtlOr;
               3'b111: alu_ctl = CtlAnd;
            endcase
         end
      end
   end

   // Operands are reduced to magnitudes at launch; the sign is restored on the last step.
   assign signed_a = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
   assign signed_b = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
   assign a_neg    = signed_a && bus_io.opA[XLEN-1];
   assign b_neg    = signed_b && bus_io.opB[XLEN-1];
   assign abs_a    = a_neg ? -bus_io.opA : bus_io.opA;
   assign abs_b    = b_neg ? -bus_io.opB : bus_io.opB;
   assign div_zero = f3[2] && (bus_io.opB == '0);
   assign div_ovf  = f3[2] && !f3[0] && (bus_io.opA == MinNeg) && (bus_io.opB == '1);
   assign fast     = div_zero || div_ovf;

   always_comb begin
      fast_res = '0;
      if (div_zero) begin
         fast_res = f3[1] ? bus_io.opA : '1;
      end else begin
         fast_res = f3[1] ? '0 : bus_io.opA;
      end
   end

   // Shared iteration datapath: mul keeps {acc, multiplier}, div keeps {remainder, quotient}.
   logic [XLEN:0]     mul_sum, div_sh, div_diff;
   logic [XLEN-1:0]   step_hi, step_lo, div_sel, div_fix, final_res;
   logic [2*XLEN-1:0] prod, prod_fix;

   assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
   assign div_sh   = {hi_q, lo_q[XLEN-1]};
   assign div_diff = div_sh - {1'b0, mcand_q};
   assign step_hi  = op_q[2] ? (div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0])
                             : mul_sum[XLEN:1];
   assign step_lo  = op_q[2] ? {lo_q[XLEN-2:0], ~div_diff[XLEN]}
                             : {mul_sum[0], lo_q[XLEN-1:1]};
   assign prod     = {step_hi, step_lo};
   assign prod_fix = neg_q ? -prod : prod;
   assign div_sel  = op_q[1] ? step_hi : step_lo;
   assign div_fix  = neg_q ? -div_sel : div_sel;
   assign final_res = op_q[2] ? div_fix :
                      (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      mcand_d  = mcand_q;
      op_d     = op_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      if (launch) begin
         hi_d    = '0;
         lo_d    = f3[2] ? abs_a : abs_b;
         mcand_d = f3[2] ? abs_b : abs_a;
         op_d    = f3;
         neg_d   = (f3[2] && f3[1]) ? a_neg : (a_neg ^ b_neg);
         cnt_d   = CNT_W'(XLEN - 1);
         if (fast) begin
            result_d = fast_res;
         end
      end else if (state_q == StBusy) begin
         hi_d = step_hi;
         lo_d = step_lo;
         if (cnt_q == '0) begin
            result_d = final_res;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q     <= '0;
         lo_q     <= '0;
         mcand_q  <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         mcand_q  <= mcand_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (launch) state_d = fast ? StDone : StBusy;
         StBusy:  if (cnt_q == '0) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Stall drops in DONE so the core retires the instruction exactly once.
   always_comb begin
      stall   = bus_io.valid && is_md && (state_q != StDone);
      md_busy = (state_q == StBusy);
      md_done = (state_q == StDone);
   end

   assign bus_io.aluCtl   = alu_ctl;
   assign bus_io.stall    = stall;
   assign bus_io.mdBusy   = md_busy;
   assign bus_io.mdDone   = md_done;
   assign bus_io.mdResult = result_q;
endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md: directed decode and mul/div cases plus randomized runs,
// all checked against a 64-bit arithmetic reference model.
module tb_alu_control_md;
   localparam int unsigned XLEN   = 32;
   localparam int          MaxCyc = 200;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   alu_control_md_if #(.XLEN(XLEN)) bus ();

   alu_control_md #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7);
      if (op == 2'b00) return 4'b0010;
      if (op == 2'b01) return 4'b0110;
      if (op == 2'b10 && f7 == 7'h01) return 4'b1111;
      case (f3)
         3'd0: return (op == 2'b10 && f7[5]) ? 4'b0110 : 4'b0010;
         3'd1: return 4'b0100;
         3'd2: return 4'b1000;
         3'd3: return 4'b1001;
         3'd4: return 4'b0011;
         3'd5: return f7[5] ? 4'b0111 : 4'b0101;
         3'd6: return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sa, sb, ub, p;
      logic [63:0] pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'h0, b});
      pu = {32'h0, a} * {32'h0, b};
      case (f3)
         3'd0: return pu[31:0];
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: return pu[63:32];
         3'd4: begin
            if (b == 0) return 32'hffff_ffff;
            if (a == 32'h8000_0000 && b == 32'hffff_ffff) return a;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hffff_ffff) return 32'h0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic chk_dec(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic v, input logic [3:0] exp);
      bus.valid  = v;
      bus.aluOp  = op;
      bus.funct3 = f3;
      bus.funct7 = f7;
      #2;
      check_eq({tag, ".ctl"}, 64'(bus.aluCtl), 64'(exp));
      check_eq({tag, ".stall"}, 64'(bus.stall), 64'(0));
      bus.valid = 1'b0;
      @(negedge clk); #1;
   endtask

   // Presents one MD instruction; starts and ends at negedge+1 with the engine idle.
   task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int poke_at, input logic [31:0] poke_v,
                         input bit drop_valid);
      logic [31:0] exp_res;
      int          exp_lat, exp_stalls, cyc, stalls, busy;
      bit          fast;
      exp_res    = ref_md(f3, a, b);
      fast       = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hffff_ffff));
      exp_lat    = fast ? 1 : XLEN + 1;
      exp_stalls = (drop_valid && poke_at < exp_lat) ? poke_at : exp_lat;
      cyc = 0; stalls = 0; busy = 0;
      bus.valid  = 1'b1;
      bus.aluOp  = 2'b10;
      bus.funct7 = 7'h01;
      bus.funct3 = f3;
      bus.opA    = a;
      bus.opB    = b;
      #1;
      while (bus.mdDone !== 1'b1 && cyc < MaxCyc) begin
         if (bus.stall === 1'b1) stalls++;
         if (bus.mdBusy === 1'b1) busy++;
         @(negedge clk); #1;
         cyc++;
         if (cyc == poke_at) begin
            bus.opA    = a ^ poke_v;
            bus.opB    = poke_v;
            bus.funct3 = f3 ^ poke_v[2:0];
            if (drop_valid) bus.valid = 1'b0;
            #1;
         end
      end
      check_eq({tag, ".lat"}, 64'(cyc), 64'(exp_lat));
      check_eq({tag, ".res"}, 64'(bus.mdResult), 64'(exp_res));
      check_eq({tag, ".stall_done"}, 64'(bus.stall), 64'(0));
      check_eq({tag, ".stalls"}, 64'(stalls), 64'(exp_stalls));
      check_eq({tag, ".busy"}, 64'(busy), 64'(exp_lat - 1));
      @(negedge clk); #1;
      check_eq({tag, ".pulse"}, 64'(bus.mdDone), 64'(0));
      check_eq({tag, ".hold"}, 64'(bus.mdResult), 64'(exp_res));
      bus.valid = 1'b0;
   endtask

   initial begin
      logic [1:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        v;
      logic [31:0] a, b;

      bus.valid = 1'b0; bus.aluOp = 2'b00; bus.funct3 = 3'b000; bus.funct7 = 7'h00;
      bus.opA = '0; bus.opB = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      check_eq("rst.busy", 64'(bus.mdBusy), 64'(0));
      check_eq("rst.done", 64'(bus.mdDone), 64'(0));
      check_eq("rst.result", 64'(bus.mdResult), 64'(0));
      check_eq("rst.stall", 64'(bus.stall), 64'(0));
      rst = 1'b0;

      chk_dec("dec.lsadd", 2'b00, 3'b101, 7'h20, 1'b1, 4'b0010);
      chk_dec("dec.brsub", 2'b01, 3'b000, 7'h00, 1'b1, 4'b0110);
      chk_dec("dec.sub",   2'b10, 3'b000, 7'h20, 1'b1, 4'b0110);
      chk_dec("dec.and",   2'b10, 3'b111, 7'h00, 1'b1, 4'b0000);
      chk_dec("dec.or",    2'b10, 3'b110, 7'h00, 1'b1, 4'b0001);
      chk_dec("dec.sra",   2'b10, 3'b101, 7'h20, 1'b1, 4'b0111);
      chk_dec("dec.addi",  2'b11, 3'b000, 7'h20, 1'b1, 4'b0010);
      chk_dec("dec.imd",   2'b11, 3'b000, 7'h01, 1'b1, 4'b0010);
      chk_dec("dec.md",    2'b10, 3'b100, 7'h01, 1'b0, 4'b1111);
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         f3 = 3'($urandom);
         case ($urandom_range(0, 3))
            0: f7 = 7'h01;
            1: f7 = 7'h20;
            2: f7 = 7'h00;
            default: f7 = 7'($urandom);
         endcase
         v = 1'($urandom);
         if (op == 2'b10 && f7 == 7'h01) v = 1'b0;
         chk_dec("dec.rnd", op, f3, f7, v, ref_ctl(op, f3, f7));
      end

      run_md("mul",   3'd0, 32'd7, 32'hffff_fffd, -1, 32'h0, 1'b0);
      run_md("mulh",  3'd1, 32'd7, 32'hffff_fffd, -1, 32'h0, 1'b0);
      run_md("mulhu", 3'd3, 32'd7, 32'hffff_fffd, -1, 32'h0, 1'b0);
      run_md("div",   3'd4, 32'hffff_ffec, 32'd3, 4, 32'h1234_5677, 1'b1);
      run_md("rem",   3'd6, 32'hffff_ffec, 32'd3, -1, 32'h0, 1'b0);
      run_md("divu",  3'd5, 32'd20, 32'd3, -1, 32'h0, 1'b0);
      run_md("remu",  3'd7, 32'd20, 32'd3, -1, 32'h0, 1'b0);

      bus.valid = 1'b1; bus.aluOp = 2'b10; bus.funct7 = 7'h01; bus.funct3 = 3'd0;
      bus.opA = 32'd5; bus.opB = 32'd9;
      repeat (10) @(negedge clk);
      #1;
      check_eq("rstmid.pre_busy", 64'(bus.mdBusy), 64'(1));
      rst = 1'b1;
      bus.valid = 1'b0;
      @(negedge clk); #1;
      check_eq("rstmid.busy", 64'(bus.mdBusy), 64'(0));
      check_eq("rstmid.done", 64'(bus.mdDone), 64'(0));
      check_eq("rstmid.result", 64'(bus.mdResult), 64'(0));
      rst = 1'b0;
      @(negedge clk); #1;
      run_md("mul3x4", 3'd0, 32'd3, 32'd4, -1, 32'h0, 1'b0);

      run_md("div0",   3'd4, 32'd5, 32'd0, -1, 32'h0, 1'b0);
      run_md("remu0",  3'd7, 32'd5, 32'd0, -1, 32'h0, 1'b0);
      run_md("divovf", 3'd4, 32'h8000_0000, 32'hffff_ffff, -1, 32'h0, 1'b0);
      run_md("removf", 3'd6, 32'h8000_0000, 32'hffff_ffff, -1, 32'h0, 1'b0);

      run_md("b2b.mul",  3'd0, 32'd6, 32'd7, 5, 32'd9, 1'b0);
      run_md("b2b.divu", 3'd5, 32'd100, 32'd7, -1, 32'h0, 1'b0);

      for (int i = 0; i < 16; i++) begin
         f3 = 3'($urandom);
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 4))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hffff_ffff; end
            2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(0, 9)); end
            default: ;
         endcase
         run_md("rnd", f3, a, b, $urandom_range(1, 30), $urandom, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
